// File: rtl/rover_vision_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rover_vision_pkg : constants and types shared by the edge-list producer     |
// |                    and the edge_list_reader packet streamer                 |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package rover_vision_pkg;

  localparam int         N_ENTRIES = 30;
  localparam int         X_W       = 11;
  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam int         IDX_W     = $clog2(N_ENTRIES + 1);

  typedef logic [X_W-1:0] xpos_t;

  typedef enum logic [2:0] {IDLE, SCAN, HDR, CNT, HI, LO, CHK} rdr_state_t;

  // Entries are zero-extended to 16 bits and split into two wire bytes.
  function automatic logic [7:0] hi_byte(input xpos_t x);
    logic [15:0] w;
    w = 16'(x);
    return w[15:8];
  endfunction

  function automatic logic [7:0] lo_byte(input xpos_t x);
    logic [15:0] w;
    w = 16'(x);
    return w[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_list_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_list_reader : snapshots the per-frame edge list and streams it as a    |
// |                    framed, XOR-checksummed byte packet over valid/ready     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module edge_list_reader
  import rover_vision_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_done,
  input  logic [N_ENTRIES*X_W-1:0] measured_list,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [7:0]               dropped
);

  rdr_state_t       state_q;
  xpos_t            snap_q [N_ENTRIES];
  logic [IDX_W-1:0] idx_q, count_q, e_q;
  logic [7:0]       chk_q, data_q, dropped_q;
  logic             valid_q;

  logic             hs_d;
  logic [IDX_W-1:0] e_d;
  logic [7:0]       chk_d;
  xpos_t            scan_ent_d, ent_cur_d, ent_nxt_d;

  // Index guards keep the one-past-the-end index of a full list off the array.
  always_comb begin
    hs_d       = valid_q & out_ready;
    e_d        = e_q + IDX_W'(1);
    chk_d      = chk_q ^ data_q;
    scan_ent_d = (idx_q < IDX_W'(N_ENTRIES)) ? snap_q[idx_q] : '0;
    ent_cur_d  = (e_q   < IDX_W'(N_ENTRIES)) ? snap_q[e_q]   : '0;
    ent_nxt_d  = (e_d   < IDX_W'(N_ENTRIES)) ? snap_q[e_d]   : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      e_q       <= '0;
      chk_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      dropped_q <= '0;
      for (int i = 0; i < N_ENTRIES; i++) snap_q[i] <= '0;
    end else begin
      if (frame_done && state_q != IDLE && dropped_q != 8'hFF)
        dropped_q <= dropped_q + 8'd1;

      unique case (state_q)
        IDLE: if (frame_done) begin
          for (int i = 0; i < N_ENTRIES; i++) snap_q[i] <= measured_list[i*X_W +: X_W];
          idx_q   <= '0;
          e_q     <= '0;
          chk_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (idx_q == IDX_W'(N_ENTRIES) || scan_ent_d == '0) begin
            count_q <= idx_q;
            data_q  <= HDR_BYTE;
            valid_q <= 1'b1;
            state_q <= HDR;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        HDR: if (hs_d) begin
          data_q  <= 8'(count_q);
          state_q <= CNT;
        end
        CNT: if (hs_d) begin
          chk_q <= chk_d;
          if (count_q == '0) begin
            data_q  <= chk_d;
            state_q <= CHK;
          end else begin
            data_q  <= hi_byte(ent_cur_d);
            state_q <= HI;
          end
        end
        HI: if (hs_d) begin
          chk_q   <= chk_d;
          data_q  <= lo_byte(ent_cur_d);
          state_q <= LO;
        end
        LO: if (hs_d) begin
          chk_q <= chk_d;
          e_q   <= e_d;
          if (e_d < count_q) begin
            data_q  <= hi_byte(ent_nxt_d);
            state_q <= HI;
          end else begin
            data_q  <= chk_d;
            state_q <= CHK;
          end
        end
        CHK: if (hs_d) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign dropped   = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_list_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_edge_list_reader : randomized self-checking bench against a packet model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_edge_list_reader;

  localparam int NE = 30;
  localparam int XW = 11;
  localparam int LW = NE * XW;

  typedef logic [7:0] byte_q_t[$];

  logic          clk, reset, frame_done, out_ready;
  logic [LW-1:0] measured_list;
  logic [7:0]    out_data, dropped;
  logic          out_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_dropped = 0;

  edge_list_reader dut (
    .clk          (clk),
    .reset        (reset),
    .frame_done   (frame_done),
    .measured_list(measured_list),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .dropped      (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list length is the first empty slot, each entry is sent as x/256 then x%256.
  function automatic byte_q_t make_packet(input logic [LW-1:0] l);
    byte_q_t q;
    int cnt = 0;
    int x;
    logic [7:0] chk;
    while (cnt < NE && l[cnt*XW +: XW] != 0) cnt++;
    q.push_back(8'hA5);
    q.push_back(8'(cnt));
    chk = 8'(cnt);
    for (int i = 0; i < cnt; i++) begin
      x = int'(l[i*XW +: XW]);
      q.push_back(8'(x / 256));
      q.push_back(8'(x % 256));
      chk = chk ^ 8'(x / 256) ^ 8'(x % 256);
    end
    q.push_back(chk);
    return q;
  endfunction

  function automatic int list_len(input logic [LW-1:0] l);
    int cnt = 0;
    while (cnt < NE && l[cnt*XW +: XW] != 0) cnt++;
    return cnt;
  endfunction

  function automatic logic [LW-1:0] rand_bits();
    logic [LW-1:0] r;
    for (int i = 0; i < LW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [LW-1:0] make_list(input int cnt);
    logic [LW-1:0] l;
    for (int i = 0; i < NE; i++) begin
      if (i < cnt)       l[i*XW +: XW] = 11'($urandom_range(1, 2047));
      else if (i == cnt) l[i*XW +: XW] = '0;
      else               l[i*XW +: XW] = 11'($urandom_range(0, 2047));
    end
    return l;
  endfunction

  // Called just after a clock edge; leaves off just after the edge that samples frame_done.
  task automatic send_frame(input logic [LW-1:0] l);
    measured_list = l;
    frame_done    = 1'b1;
    @(posedge clk); #1;
    frame_done    = 1'b0;
  endtask

  task automatic check_latency(input int cnt, input string name);
    int lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != cnt + 2) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, cnt + 2);
    end
  endtask

  // Drains bytes with out_ready asserted ready_pct% of cycles; measured_list is scrambled every cycle.
  task automatic collect(input byte_q_t exp, input int ready_pct, input int n_mid,
                         input bit chk_pulse, input int stop_after, input string name);
    int got = 0;
    int cyc = 0;
    int limit;
    bit stalled = 0;
    bit rdy;
    logic [7:0] held = '0;
    limit = (stop_after > 0) ? stop_after : exp.size();
    while (got < limit && cyc < 600) begin
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++;
          $display("FAIL %s stall_hold byte %0d: valid=%b data=%02h, expected valid=1 data=%02h",
                   name, got, out_valid, out_data, held);
        end
      end
      rdy           = ($urandom_range(0, 99) < ready_pct);
      out_ready     = rdy;
      frame_done    = 1'b0;
      measured_list = rand_bits();
      if (out_valid === 1'b1) begin
        if (rdy) begin
          n_checks++;
          if (out_data !== exp[got]) begin
            n_fail++;
            $display("FAIL %s byte %0d: got %02h, expected %02h", name, got, out_data, exp[got]);
          end
          if (chk_pulse && got == exp.size() - 1) frame_done = 1'b1;
          got++;
          if (got <= n_mid && got < exp.size() - 1) frame_done = 1'b1;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = out_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    frame_done = 1'b0;
    out_ready  = 1'b0;
    if (got < limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d bytes, expected %0d", name, got, limit);
    end
  endtask

  task automatic check_idle_after(input string name);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || dropped !== 8'(exp_dropped)) begin
      n_fail++;
      $display("FAIL %s end_state: busy=%b valid=%b dropped=%0d, expected busy=0 valid=0 dropped=%0d",
               name, busy, out_valid, dropped, exp_dropped);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || dropped !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%02h busy=%b dropped=%0d, expected 0/00/0/0",
               out_valid, out_data, busy, dropped);
    end
  endtask

  task automatic test_basic();
    logic [LW-1:0] l = '0;
    byte_q_t exp;
    l[0*XW +: XW] = 11'd100;
    l[1*XW +: XW] = 11'd200;
    exp = make_packet(l);
    send_frame(l);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic busy_after_frame: got %b, expected 1", busy);
    end
    check_latency(2, "basic");
    collect(exp, 100, 0, 0, 0, "basic");
    check_idle_after("basic");
  endtask

  task automatic test_empty();
    logic [LW-1:0] l = '0;
    send_frame(l);
    check_latency(0, "empty");
    collect(make_packet(l), 100, 0, 0, 0, "empty");
    check_idle_after("empty");
  endtask

  task automatic test_full();
    logic [LW-1:0] l;
    byte_q_t exp;
    for (int i = 0; i < NE; i++) l[i*XW +: XW] = 11'h7FF;
    exp = make_packet(l);
    n_checks++;
    if (exp.size() != 63 || exp[62] !== 8'h1E) begin
      n_fail++;
      $display("FAIL full model: got size %0d chk %02h, expected 63 and 1e", exp.size(), exp[exp.size()-1]);
    end
    send_frame(l);
    check_latency(NE, "full");
    collect(exp, 100, 0, 0, 0, "full");
    check_idle_after("full");
  endtask

  task automatic test_stall();
    logic [LW-1:0] l = '0;
    l[0*XW +: XW] = 11'd100;
    l[1*XW +: XW] = 11'd200;
    send_frame(l);
    collect(make_packet(l), 50, 0, 0, 0, "stall_case1");
    check_idle_after("stall_case1");
    for (int k = 0; k < 4; k++) begin
      l = make_list(int'($urandom_range(0, NE)));
      send_frame(l);
      collect(make_packet(l), 50, 0, 0, 0, "stall_rand");
      check_idle_after("stall_rand");
    end
  endtask

  task automatic test_random();
    logic [LW-1:0] l;
    for (int k = 0; k < 6; k++) begin
      l = make_list((k == 0) ? NE : int'($urandom_range(0, NE)));
      send_frame(l);
      check_latency(list_len(l), "random");
      collect(make_packet(l), 100, 0, 0, 0, "random");
      check_idle_after("random");
    end
  endtask

  task automatic test_drop();
    logic [LW-1:0] l = '0;
    logic [LW-1:0] l2;
    l[0*XW +: XW] = 11'd100;
    l[1*XW +: XW] = 11'd200;
    send_frame(l);
    collect(make_packet(l), 100, 3, 1, 0, "drop");
    exp_dropped += 4;
    check_idle_after("drop");
    l2 = make_list(5);
    send_frame(l2);
    check_latency(5, "drop_next");
    collect(make_packet(l2), 100, 0, 0, 0, "drop_next");
    check_idle_after("drop_next");
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] l = '0;
    l[0*XW +: XW] = 11'd100;
    l[1*XW +: XW] = 11'd200;
    send_frame(l);
    collect(make_packet(l), 100, 0, 0, 4, "reset_mid_pre");
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid at_hi1: valid=%b data=%02h, expected 1 and 00", out_valid, out_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_dropped = 0;
    check_idle_after("reset_mid");
    l = make_list(7);
    send_frame(l);
    collect(make_packet(l), 100, 0, 0, 0, "reset_mid_post");
    check_idle_after("reset_mid_post");
  endtask

  initial begin
    reset         = 1'b1;
    frame_done    = 1'b0;
    out_ready     = 1'b0;
    measured_list = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_full();
    test_stall();
    test_random();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
